// File: rtl/eink_pkg.sv
// Shared types and defaults for the e-ink frame sequencer.
package eink_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FSTART_HI,
        S_FSTART_LO,
        S_LOAD_A,
        S_LOAD_B,
        S_LATCH,
        S_GATE_HI,
        S_GATE_LO,
        S_DONE
    } seq_state_t;

    localparam int unsigned CKV_HI_DEF = 3;
    localparam int unsigned CKV_LO_DEF = 2;

    // Inactive levels of the active-low start strobes.
    localparam logic SPH_IDLE = 1'b1;
    localparam logic SPV_IDLE = 1'b1;

    // Counter width for a count of 'limit' states, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/eink_phase_timer.sv
// Loadable down-counter timing the gate/vertical-start phases.
module eink_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Terminal count is registered alongside the count it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_o  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            tc_o  <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/eink_frame_sequencer.sv
// Sequences source loading, latching and gate pulses for a multi-frame e-ink update.
module eink_frame_sequencer
    import eink_pkg::*;
#(
    parameter int unsigned H_BYTES = 8,
    parameter int unsigned V_ROWS  = 16,
    parameter int unsigned FRAMES  = 4,
    parameter int unsigned CKV_HI  = CKV_HI_DEF,
    parameter int unsigned CKV_LO  = CKV_LO_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(FRAMES):0]   frame_idx,
    input  logic [7:0]                pix_data,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic [7:0]                src_data,
    output logic                      sph,
    output logic                      cl,
    output logic                      le,
    output logic                      oe,
    output logic                      spv,
    output logic                      ckv
);

    localparam int unsigned FW   = $clog2(FRAMES) + 1;
    localparam int unsigned BW   = cnt_width(H_BYTES);
    localparam int unsigned RW   = cnt_width(V_ROWS);
    localparam int unsigned TMAX = (CKV_HI > CKV_LO) ? CKV_HI : CKV_LO;
    localparam int unsigned TW   = cnt_width(TMAX);

    seq_state_t    state_q, state_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [RW-1:0] row_q, row_d;
    logic [FW-1:0] frame_d;
    logic [7:0]    src_d;
    logic          sph_d, spv_d, cl_d, le_d, oe_d, ckv_d, busy_d, done_d, ready_d;
    logic          t_load, t_en, t_tc;
    logic [TW-1:0] t_val;

    eink_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .load_val_i (t_val),
        .en_i       (t_en),
        .tc_o       (t_tc)
    );

    // Next state; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        row_d   = row_q;
        frame_d = frame_idx;
        src_d   = src_data;
        t_load  = 1'b0;
        t_val   = '0;
        t_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FSTART_HI;
                    t_load  = 1'b1;
                    t_val   = TW'(CKV_HI - 1);
                    frame_d = '0;
                end
            end
            S_FSTART_HI: begin
                t_en = 1'b1;
                if (t_tc) begin
                    state_d = S_FSTART_LO;
                    t_load  = 1'b1;
                    t_val   = TW'(CKV_LO - 1);
                end
            end
            S_FSTART_LO: begin
                t_en = 1'b1;
                if (t_tc) begin
                    state_d = S_LOAD_A;
                    row_d   = '0;
                    byte_d  = '0;
                end
            end
            S_LOAD_A: begin
                if (pix_valid) begin
                    src_d   = pix_data;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (byte_q == BW'(H_BYTES - 1)) begin
                    state_d = S_LATCH;
                end else begin
                    byte_d  = byte_q + BW'(1);
                    state_d = S_LOAD_A;
                end
            end
            S_LATCH: begin
                state_d = S_GATE_HI;
                t_load  = 1'b1;
                t_val   = TW'(CKV_HI - 1);
            end
            S_GATE_HI: begin
                t_en = 1'b1;
                if (t_tc) begin
                    state_d = S_GATE_LO;
                    t_load  = 1'b1;
                    t_val   = TW'(CKV_LO - 1);
                end
            end
            S_GATE_LO: begin
                t_en = 1'b1;
                if (t_tc) begin
                    if (row_q == RW'(V_ROWS - 1)) begin
                        if (frame_idx < FW'(FRAMES - 1)) begin
                            frame_d = frame_idx + FW'(1);
                            state_d = S_FSTART_HI;
                            t_load  = 1'b1;
                            t_val   = TW'(CKV_HI - 1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        row_d   = row_q + RW'(1);
                        byte_d  = '0;
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a coincident start or byte capture.
        if (abort) begin
            state_d = S_IDLE;
        end

        sph_d   = SPH_IDLE;
        spv_d   = SPV_IDLE;
        cl_d    = 1'b0;
        le_d    = 1'b0;
        oe_d    = 1'b0;
        ckv_d   = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        ready_d = 1'b0;

        case (state_d)
            S_IDLE: begin
                busy_d  = 1'b0;
                frame_d = '0;
                src_d   = '0;
            end
            S_FSTART_HI: begin
                spv_d = ~SPV_IDLE;
                ckv_d = 1'b1;
            end
            S_FSTART_LO: spv_d = ~SPV_IDLE;
            S_LOAD_A: begin
                sph_d   = ~SPH_IDLE;
                ready_d = 1'b1;
            end
            S_LOAD_B: begin
                sph_d = ~SPH_IDLE;
                cl_d  = 1'b1;
            end
            S_LATCH: le_d = 1'b1;
            S_GATE_HI: begin
                ckv_d = 1'b1;
                oe_d  = 1'b1;
            end
            S_GATE_LO: ;
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            byte_q    <= '0;
            row_q     <= '0;
            frame_idx <= '0;
            src_data  <= '0;
            sph       <= SPH_IDLE;
            spv       <= SPV_IDLE;
            cl        <= 1'b0;
            le        <= 1'b0;
            oe        <= 1'b0;
            ckv       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            row_q     <= row_d;
            frame_idx <= frame_d;
            src_data  <= src_d;
            sph       <= sph_d;
            spv       <= spv_d;
            cl        <= cl_d;
            le        <= le_d;
            oe        <= oe_d;
            ckv       <= ckv_d;
            busy      <= busy_d;
            done      <= done_d;
            pix_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_eink_frame_sequencer.sv
// Directed self-checking bench for eink_frame_sequencer with a 2x2x2 panel configuration.
module tb_eink_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] frame_idx;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] src_data;
    logic       sph, cl, le, oe, spv, ckv;

    int checks = 0;
    int passed = 0;

    eink_frame_sequencer #(
        .H_BYTES (2),
        .V_ROWS  (2),
        .FRAMES  (2),
        .CKV_HI  (3),
        .CKV_LO  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .frame_idx (frame_idx),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .src_data  (src_data),
        .sph       (sph),
        .cl        (cl),
        .le        (le),
        .oe        (oe),
        .spv       (spv),
        .ckv       (ckv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge where busy should first be seen.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes a full update window from cycle 1 and gathers statistics.
    task automatic measure(input int stall_xfer, input int stall_len, input int restart_cyc,
                           output int busy_n, output int done_n, output int done_at,
                           output int xfers, output int les, output int fmax,
                           output int stall_ok);
        int stall_left;
        busy_n = 0; done_n = 0; done_at = 0; xfers = 0; les = 0; fmax = 0; stall_ok = 0;
        stall_left = stall_len;
        for (int c = 1; c <= 120; c++) begin
            start = (c == restart_cyc);
            if (pix_ready && (xfers == stall_xfer) && (stall_left > 0)) begin
                pix_valid = 1'b0;
                stall_left--;
                if (pix_ready && !cl && !sph) stall_ok++;
            end else begin
                pix_valid = 1'b1;
            end
            if (pix_ready && pix_valid) xfers++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = c;
            end
            if (le) les++;
            if (int'(frame_idx) > fmax) fmax = int'(frame_idx);
            @(negedge clk);
        end
        start = 1'b0;
        pix_valid = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({sph, spv, cl, le, oe, ckv, busy, done, pix_ready} !== 9'b110000000)
            $display("FAIL reset_strobes got %b expected 110000000",
                     {sph, spv, cl, le, oe, ckv, busy, done, pix_ready});
        else passed++;
        checks++;
        if ({src_data, frame_idx} !== 10'd0)
            $display("FAIL reset_data got %h/%0d expected 00/0", src_data, frame_idx);
        else passed++;
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_abort_wins got busy=%b expected 0", busy);
        else passed++;
        @(negedge clk);
        checks++;
        if ({busy, spv} !== 2'b01) $display("FAIL idle_abort_stays got %b expected 01", {busy, spv});
        else passed++;
    endtask

    task automatic test_basic();
        int bn, dn, da, xf, ln, fm, so;
        pulse_start();
        checks++;
        if ({busy, spv, ckv, frame_idx} !== 5'b10100)
            $display("FAIL basic_first_cycle got %b expected 10100", {busy, spv, ckv, frame_idx});
        else passed++;
        measure(-1, 0, 0, bn, dn, da, xf, ln, fm, so);
        checks++;
        if (bn !== 50) $display("FAIL basic_busy_cycles got %0d expected 50", bn); else passed++;
        checks++;
        if (dn !== 1) $display("FAIL basic_done_count got %0d expected 1", dn); else passed++;
        checks++;
        if (da !== 51) $display("FAIL basic_done_cycle got %0d expected 51", da); else passed++;
        checks++;
        if (xf !== 8) $display("FAIL basic_transfers got %0d expected 8", xf); else passed++;
        checks++;
        if (fm !== 1) $display("FAIL basic_frame_max got %0d expected 1", fm); else passed++;
        checks++;
        if ({busy, frame_idx} !== 3'b000)
            $display("FAIL basic_back_idle got %b expected 000", {busy, frame_idx});
        else passed++;
    endtask

    task automatic test_data();
        logic [7:0] exp_b;
        int ncl, nle;
        logic hs_prev;
        exp_b = 8'h11; ncl = 0; nle = 0; hs_prev = 1'b0;
        pix_data = 8'h11;
        pulse_start();
        for (int c = 1; c <= 60; c++) begin
            if (hs_prev) pix_data = pix_data + 8'h11;
            if (cl) begin
                checks++;
                if (src_data !== exp_b)
                    $display("FAIL data_byte%0d got %h expected %h", ncl, src_data, exp_b);
                else passed++;
                exp_b = exp_b + 8'h11;
                ncl++;
            end
            if (le) nle++;
            hs_prev = pix_ready && pix_valid;
            @(negedge clk);
        end
        checks++;
        if (ncl !== 8) $display("FAIL data_cl_pulses got %0d expected 8", ncl); else passed++;
        checks++;
        if (nle !== 4) $display("FAIL data_le_pulses got %0d expected 4", nle); else passed++;
        pix_data = 8'h00;
    endtask

    task automatic test_stall();
        int bn, dn, da, xf, ln, fm, so;
        pulse_start();
        measure(1, 5, 0, bn, dn, da, xf, ln, fm, so);
        checks++;
        if (so !== 5) $display("FAIL stall_strobes_held got %0d expected 5", so); else passed++;
        checks++;
        if (bn !== 55) $display("FAIL stall_busy_cycles got %0d expected 55", bn); else passed++;
        checks++;
        if (xf !== 8) $display("FAIL stall_transfers got %0d expected 8", xf); else passed++;
        checks++;
        if (dn !== 1) $display("FAIL stall_done_count got %0d expected 1", dn); else passed++;
    endtask

    task automatic test_abort();
        int bn, dn, da, xf, ln, fm, so;
        bit found;
        int dseen;
        found = 1'b0;
        pulse_start();
        for (int c = 0; c < 100 && !found; c++) begin
            if (frame_idx == 2'd1 && oe) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) $display("FAIL abort_reach_gate got 0 expected 1"); else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({oe, ckv, busy, sph, spv, pix_ready, frame_idx} !== 8'b00011000)
            $display("FAIL abort_outputs got %b expected 00011000",
                     {oe, ckv, busy, sph, spv, pix_ready, frame_idx});
        else passed++;
        dseen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) dseen++;
            @(negedge clk);
        end
        checks++;
        if (dseen !== 0) $display("FAIL abort_no_done got %0d expected 0", dseen); else passed++;
        pulse_start();
        measure(-1, 0, 0, bn, dn, da, xf, ln, fm, so);
        checks++;
        if (bn !== 50) $display("FAIL abort_rerun_busy got %0d expected 50", bn); else passed++;
        checks++;
        if (dn !== 1) $display("FAIL abort_rerun_done got %0d expected 1", dn); else passed++;
    endtask

    task automatic test_restart_ignored();
        int bn, dn, da, xf, ln, fm, so;
        pulse_start();
        measure(-1, 0, 20, bn, dn, da, xf, ln, fm, so);
        checks++;
        if (dn !== 1) $display("FAIL restart_done_count got %0d expected 1", dn); else passed++;
        checks++;
        if (da !== 51) $display("FAIL restart_done_cycle got %0d expected 51", da); else passed++;
        checks++;
        if (bn !== 50) $display("FAIL restart_busy_cycles got %0d expected 50", bn); else passed++;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        pulse_start();
        for (int c = 0; c < 40 && !found; c++) begin
            if (pix_ready) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found || sph !== 1'b0)
            $display("FAIL arst_reach_load got %b expected 10", {found, sph});
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sph, spv, pix_ready, busy, cl, ckv} !== 6'b110000)
            $display("FAIL arst_immediate got %b expected 110000",
                     {sph, spv, pix_ready, busy, cl, ckv});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sph, spv, pix_ready, frame_idx} !== 6'b011000)
            $display("FAIL arst_stays_idle got %b expected 011000",
                     {busy, sph, spv, pix_ready, frame_idx});
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pix_valid = 1'b1;
        pix_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_start_abort_idle();
        test_basic();
        test_data();
        test_stall();
        test_abort();
        test_restart_ignored();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
